// File: rtl/store_rmw_pkg.sv
// ============================================================================
// store_rmw_pkg : size encodings and FSM state type shared by the store RMW unit
// Rev 1.0
// ============================================================================
`default_nettype none

package store_rmw_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_MERGE = 3'd2,
      ST_WR    = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

   // Illegal size code, or a halfword/word whose address is not naturally aligned.
   function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      unique case (size)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = addr_lo[0];
         SIZE_W:  bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_merge.sv
// ============================================================================
// store_lane_merge : little-endian byte/halfword insertion into an existing word
// Rev 1.0
// ============================================================================
`default_nettype none

module store_lane_merge
   import store_rmw_pkg::*;
(
   input  logic [31:0] old_word_i,
   input  logic [31:0] new_data_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   output logic [31:0] merged_o
);

   always_comb begin
      merged_o = old_word_i;
      unique case (size_i)
         SIZE_B: begin
            unique case (addr_lo_i)
               2'd0: merged_o[7:0]   = new_data_i[7:0];
               2'd1: merged_o[15:8]  = new_data_i[7:0];
               2'd2: merged_o[23:16] = new_data_i[7:0];
               default: merged_o[31:24] = new_data_i[7:0];
            endcase
         end
         SIZE_H: begin
            if (addr_lo_i[1]) merged_o[31:16] = new_data_i[15:0];
            else              merged_o[15:0]  = new_data_i[15:0];
         end
         default: merged_o = new_data_i;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/store_rmw.sv
// ============================================================================
// store_rmw : sub-word store via read-modify-write of a word-wide memory
// Rev 1.0
// ============================================================================
`default_nettype none

module store_rmw
   import store_rmw_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] mem_addr,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   output logic        done,
   output logic        err
);

   state_e      state_q, state_d;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;   // holds wdata until MERGE, then the merged word
   logic [31:0] merged_d;
   logic        accept;

   assign accept = (state_q == ST_IDLE) && req_valid;

   store_lane_merge u_merge (
      .old_word_i (mem_rdata),
      .new_data_i (data_q),
      .size_i     (size_q),
      .addr_lo_i  (addr_q[1:0]),
      .merged_o   (merged_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         size_q  <= 2'b00;
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            size_q <= req_size;
            addr_q <= req_addr;
            data_q <= req_wdata;
         end else if (state_q == ST_MERGE) begin
            data_q <= merged_d;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      done      = 1'b0;
      err       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_is_bad(req_size, req_addr[1:0])) state_d = ST_ERR;
               else if (req_size == SIZE_W)            state_d = ST_WR;
               else                                     state_d = ST_RD;
            end
         end
         ST_RD: begin
            mem_re   = 1'b1;
            mem_addr = {addr_q[31:2], 2'b00};
            state_d  = ST_MERGE;
         end
         ST_MERGE: state_d = ST_WR;
         ST_WR: begin
            mem_we    = 1'b1;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_wdata = data_q;
            done      = 1'b1;
            state_d   = ST_IDLE;
         end
         ST_ERR: begin
            err     = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

`default_nettype wire
